// File: rtl/max_pool_2x2_stream_pkg.sv
// Shared helpers for the 2x2/stride-2 max-pooling stage.
//   dim_ok     : image dimension legality (even and at least 2)
//   idx_width  : index width for a table of n entries, never below 1 bit
package max_pool_2x2_stream_pkg;

    function automatic bit dim_ok(input int n);
        return (n >= 2) && ((n % 2) == 0);
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/max_pool_2x2_stream_row_buf.sv
// Half-width row buffer holding the horizontal pair maxima of an even row
// until the matching odd row arrives.
// Ports:
//   clk      : clock, rising edge
//   we_i     : write enable
//   addr_i   : entry index (shared by the write and the read port)
//   wdata_i  : value written to entry addr_i
//   rdata_o  : asynchronous read of entry addr_i
// Plain flops without reset: every entry is written on an even row before it
// is read on the following odd row, so the power-up content never matters.
module pool_row_buf #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 14,
    parameter int AW         = 4
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [AW-1:0]         addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] rd_vec [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [DATA_WIDTH-1:0] entry_q;

            always_ff @(posedge clk) begin
                if (we_i && (addr_i == AW'(gi))) begin
                    entry_q <= wdata_i;
                end
            end

            assign rd_vec[gi] = entry_q;
        end
    endgenerate

    assign rdata_o = rd_vec[addr_i];

endmodule

// File: rtl/max_pool_2x2_stream.sv
// Streaming 2x2/stride-2 max pooling of one channel's feature map.
// Input pixels arrive in raster order; the pooled map (IMG_W/2 x IMG_H/2)
// leaves in raster order, one cycle after the beat that completes each block.
// Ports:
//   clk, rst_n           : clock and asynchronous active-low reset
//   clr                  : synchronous frame abort (wins over a same-cycle beat)
//   in_valid/in_ready    : input handshake, in_data signed pixel
//   out_valid/out_ready  : output handshake, out_data signed pooled pixel
//   frame_done           : one-cycle pulse after the last pooled pixel is accepted
module max_pool_2x2_stream
    import max_pool_2x2_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  frame_done
);

    generate
        if (!dim_ok(IMG_W) || !dim_ok(IMG_H)) begin : g_dim_check
            $error("max_pool_2x2_stream: IMG_W and IMG_H must be even and >= 2");
        end
    endgenerate

    localparam int CW     = $clog2(IMG_W);
    localparam int RW     = $clog2(IMG_H);
    localparam int HALF_W = IMG_W / 2;
    localparam int AW     = idx_width(HALF_W);

    function automatic logic signed [DATA_WIDTH-1:0] smax(
        input logic signed [DATA_WIDTH-1:0] a,
        input logic signed [DATA_WIDTH-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    logic [CW-1:0]                col_q;
    logic [RW-1:0]                row_q;
    logic signed [DATA_WIDTH-1:0] pair_q;
    logic signed [DATA_WIDTH-1:0] out_data_q;
    logic                         out_valid_q;
    logic                         last_q;
    logic                         frame_done_q;

    logic                         can_take;
    logic                         beat;
    logic                         accept;
    logic                         col_last;
    logic                         row_last;
    logic                         emit;
    logic                         rb_we;
    logic [AW-1:0]                rb_addr;
    logic signed [DATA_WIDTH-1:0] pair_max;
    logic signed [DATA_WIDTH-1:0] pool_max;
    logic [DATA_WIDTH-1:0]        rb_rdata;

    // Space exists when nothing is pending or the pending result leaves this
    // cycle. rst_n is only folded into the visible in_ready; the flops are held
    // in reset anyway, so the internal beat does not need it.
    assign can_take = ~out_valid_q | out_ready;
    assign in_ready = rst_n & can_take;

    assign beat     = in_valid & can_take & ~clr;
    assign accept   = out_valid_q & out_ready;
    assign col_last = (col_q == CW'(IMG_W - 1));
    assign row_last = (row_q == RW'(IMG_H - 1));

    // Odd columns close a horizontal pair: even rows park it in the row
    // buffer, odd rows combine it with the parked pair to finish a block.
    assign pair_max = smax(pair_q, in_data);
    assign pool_max = smax(rb_rdata, pair_max);
    assign rb_we    = beat & col_q[0] & ~row_q[0];
    assign emit     = beat & col_q[0] &  row_q[0];
    assign rb_addr  = AW'(col_q >> 1);

    pool_row_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (HALF_W),
        .AW         (AW)
    ) u_row_buf (
        .clk     (clk),
        .we_i    (rb_we),
        .addr_i  (rb_addr),
        .wdata_i (pair_max),
        .rdata_o (rb_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            pair_q       <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            last_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else if (clr) begin
            col_q        <= '0;
            row_q        <= '0;
            out_valid_q  <= 1'b0;
            last_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= accept & last_q;

            if (beat) begin
                if (col_last) begin
                    col_q <= '0;
                    row_q <= row_last ? '0 : row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
                if (!col_q[0]) begin
                    pair_q <= in_data;
                end
            end

            // A reload in the accept cycle keeps full throughput.
            if (emit) begin
                out_data_q  <= pool_max;
                out_valid_q <= 1'b1;
                last_q      <= row_last & col_last;
            end else if (accept) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_max_pool_2x2_stream.sv
module tb_max_pool_2x2_stream;

    localparam int DW   = 8;
    localparam int W    = 4;
    localparam int H    = 4;
    localparam int NPIX = W * H;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_ready = 1'b1;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          frame_done;

    max_pool_2x2_stream #(
        .DATA_WIDTH (DW),
        .IMG_W      (W),
        .IMG_H      (H)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic signed [31:0] got,
                             input logic signed [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, expv);
        end
    endtask

    // ---------------- reference model ----------------
    // Records every accepted input pixel of the current frame; when the pixel
    // closing a 2x2 block arrives, the block maximum is queued as expected.
    typedef struct {
        int data;
        bit last;
    } exp_t;

    int   frm [NPIX];
    exp_t exp_q [$];
    int   pix_idx = 0;
    bit   fd_pend = 1'b0;
    int   n_out = 0;
    int   n_fd = 0;
    int   cyc = 0;
    bit   rnd_bp = 1'b0;

    exp_t mon_e;
    int   mon_r, mon_c;
    bit   mon_fd_next;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int blk_max(input int r, input int c);
        return max2(max2(frm[(r-1)*W + c-1], frm[(r-1)*W + c]),
                    max2(frm[r*W + c-1],     frm[r*W + c]));
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            pix_idx = 0;
            fd_pend = 1'b0;
        end else begin
            mon_fd_next = 1'b0;
            if (fd_pend || frame_done) check_val("frame_done", frame_done, fd_pend);
            if (frame_done) n_fd++;
            if (clr) begin
                exp_q.delete();
                pix_idx = 0;
            end else begin
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check_val("unexpected_out", $signed(out_data), 32'sd9999);
                    end else begin
                        mon_e = exp_q.pop_front();
                        $display("out #%0d data=%0d exp=%0d last=%0d", n_out,
                                 $signed(out_data), mon_e.data, mon_e.last);
                        check_val("out_data", $signed(out_data), mon_e.data);
                        mon_fd_next = mon_e.last;
                        n_out++;
                    end
                end
                if (in_valid && in_ready) begin
                    frm[pix_idx] = int'($signed(in_data));
                    mon_r = pix_idx / W;
                    mon_c = pix_idx % W;
                    if ((mon_r % 2 == 1) && (mon_c % 2 == 1)) begin
                        mon_e.data = blk_max(mon_r, mon_c);
                        mon_e.last = (mon_r == H-1) && (mon_c == W-1);
                        exp_q.push_back(mon_e);
                    end
                    pix_idx = (pix_idx + 1) % NPIX;
                end
            end
            fd_pend = mon_fd_next;
        end
    end

    always @(posedge clk) begin
        if (rnd_bp) begin
            #1;
            out_ready = ($urandom_range(0, 1) == 1);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    task automatic send_pix(input int v, input bit gaps);
        bit acc;
        int budget;
        if (gaps && ($urandom_range(0, 3) == 0)) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = v[DW-1:0];
        acc      = 1'b0;
        budget   = 0;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready && !clr;
            @(posedge clk); #1;
            budget++;
            if (!acc && budget >= 400) begin
                check_val("send_timeout", budget, 0);
                acc = 1'b1;
            end
        end
    endtask

    task automatic send_frame(input int px [NPIX], input int count, input bit gaps);
        for (int i = 0; i < count; i++) send_pix(px[i], gaps);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || out_valid) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check_val("drain_empty", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    int f0 [NPIX];
    int f1 [NPIX];
    int out0, fd0, start_cyc, wk;

    initial begin
        for (int i = 0; i < NPIX; i++) f0[i] = i;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_data", out_data, 0);
        check_val("rst_frame_done", frame_done, 0);
        check_val("rst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // 1: ramp frame, full throughput
        out0 = n_out; fd0 = n_fd; start_cyc = cyc;
        send_frame(f0, NPIX, 1'b0);
        check_val("t1_no_stall_cycles", cyc - start_cyc, NPIX);
        in_valid = 1'b0;
        drain();
        check_val("t1_outputs", n_out - out0, 4);
        check_val("t1_frame_done", n_fd - fd0, 1);

        // 2: signed values, then extremes
        for (int i = 0; i < NPIX; i++) f1[i] = -8;
        f1[1*W + 1] = -1;
        f1[2*W + 1] = -2;
        send_frame(f1, NPIX, 1'b0);
        for (int i = 0; i < NPIX; i++) f1[i] = -128;
        f1[0] = 127; f1[6] = -127; f1[15] = 127; f1[13] = 0;
        send_frame(f1, NPIX, 1'b0);
        in_valid = 1'b0;
        drain();

        // 3: backpressure at first output
        out_ready = 1'b0;
        out0 = n_out;
        fork
            send_frame(f0, NPIX, 1'b0);
            begin
                wk = 0;
                while (!out_valid && wk < 100) begin
                    @(negedge clk);
                    wk++;
                end
                check_val("t3_out_valid_seen", out_valid, 1);
                for (int j = 0; j < 5; j++) begin
                    @(negedge clk);
                    check_val("t3_hold_data", $signed(out_data), 5);
                    check_val("t3_in_ready_low", in_ready, 0);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        in_valid = 1'b0;
        drain();
        check_val("t3_outputs", n_out - out0, 4);

        // 4: back-to-back frames
        out0 = n_out; fd0 = n_fd;
        for (int i = 0; i < NPIX; i++) f1[i] = i + 16;
        send_frame(f0, NPIX, 1'b0);
        send_frame(f1, NPIX, 1'b0);
        in_valid = 1'b0;
        drain();
        check_val("t4_outputs", n_out - out0, 8);
        check_val("t4_frame_done", n_fd - fd0, 2);

        // 5: clr after 6 pixels with a colliding beat
        send_frame(f0, 6, 1'b0);
        clr = 1'b1; in_valid = 1'b1; in_data = 8'd6;
        @(posedge clk); #1;
        clr = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check_val("t5_clr_out_valid", out_valid, 0);
        @(posedge clk); #1;
        out0 = n_out; fd0 = n_fd;
        send_frame(f0, NPIX, 1'b0);
        in_valid = 1'b0;
        drain();
        check_val("t5_outputs", n_out - out0, 4);
        check_val("t5_frame_done", n_fd - fd0, 1);

        // 6: async reset while an output is pending
        out_ready = 1'b0;
        send_frame(f0, 6, 1'b0);
        in_valid = 1'b0;
        check_val("t6_pending", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check_val("t6_rst_out_valid", out_valid, 0);
        check_val("t6_rst_in_ready", in_ready, 0);
        @(negedge clk);
        check_val("t6_rst_in_ready_hold", in_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        out0 = n_out;
        send_frame(f0, NPIX, 1'b0);
        in_valid = 1'b0;
        drain();
        check_val("t6_outputs", n_out - out0, 4);

        // random frames with input gaps and random backpressure
        out0 = n_out; fd0 = n_fd;
        rnd_bp = 1'b1;
        for (int fr = 0; fr < 8; fr++) begin
            for (int i = 0; i < NPIX; i++) f1[i] = $urandom_range(0, 255) - 128;
            send_frame(f1, NPIX, 1'b1);
        end
        in_valid = 1'b0;
        rnd_bp = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        drain();
        check_val("rnd_outputs", n_out - out0, 32);
        check_val("rnd_frame_done", n_fd - fd0, 8);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
